// File: rtl/btn_debounce_step.sv
// Push-button conditioner: per channel a two-flop synchronizer, a consecutive-sample
// debounce, and a press/release strobe generator with optional auto-repeat.
module btn_debounce_step #(
  parameter int              NBTN            = 5,
  parameter int              DEBOUNCE_CYCLES = 1000000,
  parameter int              REPEAT_DELAY    = 50000000,
  parameter int              REPEAT_PERIOD   = 10000000,
  parameter logic [NBTN-1:0] REPEAT_EN       = {NBTN{1'b0}}
) (
  input  logic            clk,
  input  logic            clr,
  input  logic [NBTN-1:0] btn_raw,
  output logic [NBTN-1:0] btn_level,
  output logic [NBTN-1:0] btn_press,
  output logic [NBTN-1:0] btn_release
);

  localparam int DCW  = $clog2(DEBOUNCE_CYCLES);
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RCW  = $clog2(RMAX);

  localparam logic [DCW-1:0] DB_LAST = DCW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RCW-1:0] RD_LAST = RCW'(REPEAT_DELAY - 1);
  localparam logic [RCW-1:0] RP_LAST = RCW'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    REPEAT = 2'd2
  } rpt_state_t;

  for (genvar i = 0; i < NBTN; i++) begin : g_ch
    logic           sync_p0, sync_p1;
    logic           stable_p2;
    logic [DCW-1:0] cnt_p2;
    logic           rise, fall;
    rpt_state_t     state, state_nxt;
    logic [RCW-1:0] rc, rc_nxt;
    logic           press_nxt, release_nxt;
    logic           press_q, release_q;

    // Stage p0/p1: two-flop synchronizer
    always_ff @(posedge clk) begin
      if (clr) begin
        sync_p0 <= 1'b0;
        sync_p1 <= 1'b0;
      end else begin
        sync_p0 <= btn_raw[i];
        sync_p1 <= sync_p0;
      end
    end

    // A change is accepted on the edge that sees the last of the consecutive differing samples.
    assign rise = (sync_p1 != stable_p2) && (cnt_p2 == DB_LAST) &&  sync_p1;
    assign fall = (sync_p1 != stable_p2) && (cnt_p2 == DB_LAST) && !sync_p1;

    // Stage p2: debounce counter and accepted level
    always_ff @(posedge clk) begin
      if (clr) begin
        stable_p2 <= 1'b0;
        cnt_p2    <= '0;
      end else if (sync_p1 == stable_p2) begin
        cnt_p2    <= '0;
      end else if (cnt_p2 == DB_LAST) begin
        stable_p2 <= sync_p1;
        cnt_p2    <= '0;
      end else begin
        cnt_p2    <= cnt_p2 + 1'b1;
      end
    end

    always_comb begin
      state_nxt   = state;
      rc_nxt      = rc;
      press_nxt   = 1'b0;
      release_nxt = 1'b0;
      if (fall) begin
        // Release wins over any repeat strobe due in this cycle.
        release_nxt = 1'b1;
        state_nxt   = IDLE;
        rc_nxt      = '0;
      end else begin
        case (state)
          IDLE: begin
            if (rise) begin
              press_nxt = 1'b1;
              rc_nxt    = '0;
              state_nxt = DELAY;
            end
          end
          DELAY: begin
            if (rc == RD_LAST) begin
              if (REPEAT_EN[i]) begin
                press_nxt = 1'b1;
                rc_nxt    = '0;
                state_nxt = REPEAT;
              end
            end else begin
              rc_nxt = rc + 1'b1;
            end
          end
          REPEAT: begin
            if (rc == RP_LAST) begin
              press_nxt = 1'b1;
              rc_nxt    = '0;
            end else begin
              rc_nxt = rc + 1'b1;
            end
          end
          default: begin
            state_nxt = IDLE;
            rc_nxt    = '0;
          end
        endcase
      end
    end

    always_ff @(posedge clk) begin
      if (clr) begin
        state     <= IDLE;
        rc        <= '0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
      end else begin
        state     <= state_nxt;
        rc        <= rc_nxt;
        press_q   <= press_nxt;
        release_q <= release_nxt;
      end
    end

    assign btn_level[i]   = stable_p2;
    assign btn_press[i]   = press_q;
    assign btn_release[i] = release_q;
  end

endmodule

// File: tb/tb_btn_debounce_step.sv
// Bench for btn_debounce_step: directed scenarios with fixed expected edges, then random
// button activity checked cycle by cycle against a sliding-window / due-time reference model.
module tb_btn_debounce_step;

  localparam int         NB  = 2;
  localparam int         D   = 4;
  localparam int         RD  = 10;
  localparam int         RP  = 3;
  localparam logic [1:0] REN = 2'b01;

  logic          clk;
  logic          clr;
  logic [NB-1:0] btn_raw;
  logic [NB-1:0] btn_level;
  logic [NB-1:0] btn_press;
  logic [NB-1:0] btn_release;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  bit         rawq[NB][$];
  bit         s2q[NB][$];
  logic [1:0] m_level;
  logic [1:0] m_press;
  logic [1:0] m_release;
  bit         held[NB];
  int         due[NB];
  int         edge_n = 0;

  btn_debounce_step #(
    .NBTN           (NB),
    .DEBOUNCE_CYCLES(D),
    .REPEAT_DELAY   (RD),
    .REPEAT_PERIOD  (RP),
    .REPEAT_EN      (REN)
  ) dut (
    .clk        (clk),
    .clr        (clr),
    .btn_raw    (btn_raw),
    .btn_level  (btn_level),
    .btn_press  (btn_press),
    .btn_release(btn_release)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // A new level is accepted when the last D synchronized samples all differ from it.
  // Repeat strobes fall at press_edge + RD, then every RP edges, while the button is held.
  task automatic model_edge(input logic [1:0] raw, input logic rst);
    bit s2;
    bit acc;
    edge_n++;
    m_press   = '0;
    m_release = '0;
    for (int ch = 0; ch < NB; ch++) begin
      if (rst) begin
        rawq[ch].delete();
        s2q[ch].delete();
        m_level[ch] = 1'b0;
        held[ch]    = 1'b0;
      end else begin
        s2 = (rawq[ch].size() >= 2) ? rawq[ch][rawq[ch].size()-2] : 1'b0;
        rawq[ch].push_back(raw[ch]);
        if (rawq[ch].size() > 2) void'(rawq[ch].pop_front());
        s2q[ch].push_back(s2);
        if (s2q[ch].size() > D) void'(s2q[ch].pop_front());
        acc = (s2q[ch].size() == D);
        for (int k = 0; k < s2q[ch].size(); k++)
          if (s2q[ch][k] == m_level[ch]) acc = 1'b0;
        if (acc) begin
          m_level[ch] = ~m_level[ch];
          if (m_level[ch]) begin
            m_press[ch] = 1'b1;
            held[ch]    = 1'b1;
            due[ch]     = edge_n + RD;
          end else begin
            m_release[ch] = 1'b1;
            held[ch]      = 1'b0;
          end
        end else if (held[ch] && REN[ch] && edge_n == due[ch]) begin
          m_press[ch] = 1'b1;
          due[ch]     = edge_n + RP;
        end
      end
    end
  endtask

  task automatic step(input logic [1:0] raw, input logic rst);
    btn_raw = raw;
    clr     = rst;
    @(posedge clk);
    model_edge(raw, rst);
    #1;
    chk("model_level",   32'(btn_level),   32'(m_level));
    chk("model_press",   32'(btn_press),   32'(m_press));
    chk("model_release", 32'(btn_release), 32'(m_release));
    chk("press_and_release", 32'(btn_press & btn_release), 32'd0);
  endtask

  task automatic do_reset();
    step(2'b00, 1'b1);
    step(2'b00, 1'b1);
  endtask

  initial begin
    logic [1:0] raw;
    logic [1:0] ep, er, el;
    int         run[NB];
    int         npress;

    btn_raw = '0;
    clr     = 1'b1;

    do_reset();
    chk("reset_level",   32'(btn_level),   32'd0);
    chk("reset_press",   32'(btn_press),   32'd0);
    chk("reset_release", 32'(btn_release), 32'd0);

    // Clean press on both channels, auto-repeat on channel 0, release landing on a repeat edge
    for (int e = 0; e <= 33; e++) begin
      step((e < 25) ? 2'b11 : 2'b00, 1'b0);
      ep = (e == 5) ? 2'b11 :
           (e == 15 || e == 18 || e == 21 || e == 24 || e == 27) ? 2'b01 : 2'b00;
      er = (e == 30) ? 2'b11 : 2'b00;
      el = (e >= 5 && e < 30) ? 2'b11 : 2'b00;
      chk($sformatf("hold_press_e%0d", e),   32'(btn_press),   32'(ep));
      chk($sformatf("hold_release_e%0d", e), 32'(btn_release), 32'(er));
      chk($sformatf("hold_level_e%0d", e),   32'(btn_level),   32'(el));
    end

    // Three-cycle glitch is rejected
    do_reset();
    for (int e = 0; e <= 10; e++) begin
      step((e < 3) ? 2'b01 : 2'b00, 1'b0);
      chk($sformatf("glitch3_e%0d", e), 32'({btn_level, btn_press, btn_release}), 32'd0);
    end

    // Four-cycle pulse is accepted, then released
    do_reset();
    for (int e = 0; e <= 12; e++) begin
      step((e < 4) ? 2'b01 : 2'b00, 1'b0);
      chk($sformatf("pulse4_press_e%0d", e),   32'(btn_press),   32'((e == 5) ? 2'b01 : 2'b00));
      chk($sformatf("pulse4_release_e%0d", e), 32'(btn_release), 32'((e == 9) ? 2'b01 : 2'b00));
      chk($sformatf("pulse4_level_e%0d", e),   32'(btn_level),   32'((e >= 5 && e < 9) ? 2'b01 : 2'b00));
    end

    // Bounce restarts the count: pattern 1,1,0 then held high
    do_reset();
    npress = 0;
    for (int e = 0; e <= 14; e++) begin
      step((e == 2) ? 2'b00 : 2'b01, 1'b0);
      if (btn_press[0]) npress++;
      chk($sformatf("bounce_press_e%0d", e), 32'(btn_press), 32'((e == 8) ? 2'b01 : 2'b00));
    end
    chk("bounce_press_count", 32'(npress), 32'd1);

    // Reset mid-operation discards progress and emits no release
    do_reset();
    for (int e = 0; e <= 20; e++) begin
      step(2'b01, (e == 12) ? 1'b1 : 1'b0);
      chk($sformatf("midrst_press_e%0d", e), 32'(btn_press),
          32'((e == 5 || e == 18) ? 2'b01 : 2'b00));
      chk($sformatf("midrst_release_e%0d", e), 32'(btn_release), 32'd0);
      if (e == 12) chk("midrst_level_cleared", 32'(btn_level), 32'd0);
    end

    // Random button activity with occasional resets
    do_reset();
    raw = 2'b00;
    for (int ch = 0; ch < NB; ch++) run[ch] = 0;
    for (int c = 0; c < 3000; c++) begin
      for (int ch = 0; ch < NB; ch++) begin
        if (run[ch] == 0) begin
          raw[ch] = 1'($urandom_range(0, 1));
          run[ch] = ($urandom_range(0, 7) == 0) ? $urandom_range(10, 40) : $urandom_range(1, 6);
        end
        run[ch]--;
      end
      step(raw, ($urandom_range(0, 249) == 0) ? 1'b1 : 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
